// File: rtl/baud_gen_pkg.sv
// Shared constants for the fractional baud generator: reset divisor,
// minimum legal integer divisor and core indices.
package baud_gen_pkg;
    localparam int DEF_DIV_INT  = 325;
    localparam int DEF_DIV_FRAC = 8;
    localparam int MIN_DIV_INT  = 2;

    localparam int CORE_TX   = 0;
    localparam int CORE_RX   = 1;
    localparam int NUM_CORES = 2;
endpackage

// File: rtl/baud_div_core.sv
// One fractional divider: base counter with fractional accumulator,
// oversample counter and tick decode.
module baud_div_core
    import baud_gen_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              tick_mid
);
    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic [OS_W-1:0]   os_cnt;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W:0]    last;

    // acc only moves at period end, so the carry (and P) is fixed for a whole period
    assign acc_sum  = {1'b0, acc} + {1'b0, div_frac};
    assign last     = {1'b0, div_int} - (DIV_W+1)'(!acc_sum[FRAC_W]);

    // >= lets a counter left beyond a freshly shortened period wrap at once
    assign tick_os  = en && (cnt >= last);
    assign tick_bit = tick_os && (os_cnt == OS_W'(OVERSAMPLE - 1));
    assign tick_mid = tick_os && (os_cnt == OS_W'(OVERSAMPLE/2 - 1));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt    <= '0;
            acc    <= '0;
            os_cnt <= '0;
        end else if (clr) begin
            cnt    <= '0;
            acc    <= '0;
            os_cnt <= '0;
        end else if (tick_os) begin
            cnt    <= '0;
            acc    <= acc_sum[FRAC_W-1:0];
            os_cnt <= os_cnt + OS_W'(1);
        end else if (en) begin
            cnt    <= cnt + (DIV_W+1)'(1);
        end
    end
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: tx and rx divider cores sharing one divisor,
// with a valid/ready divisor update that lands on a tx bit boundary.
module baud_gen_frac
    import baud_gen_pkg::*;
#(
    parameter int DIV_W            = 16,
    parameter int FRAC_W           = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = DEF_DIV_INT,
    parameter int DEFAULT_DIV_FRAC = DEF_DIV_FRAC
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_err,
    input  logic              rx_realign,
    output logic              tick_tx,
    output logic              tick_os_rx,
    output logic              tick_rx_mid
);
    logic [DIV_W-1:0]  act_int,  pend_int;
    logic [FRAC_W-1:0] act_frac, pend_frac;
    logic              pend_vld;
    logic              xfer, bad, apply;

    logic [NUM_CORES-1:0] core_clr, tick_os, tick_bit, tick_mid;
    logic                 unused_ticks;

    assign cfg_ready = !pend_vld;
    assign xfer      = cfg_valid && cfg_ready;
    assign bad       = cfg_div_int < DIV_W'(MIN_DIV_INT);
    // swap only on a tx bit boundary unless the cores are idle or being cleared
    assign apply     = pend_vld && (tick_bit[CORE_TX] || !en || sync_clr);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            act_int   <= DIV_W'(DEFAULT_DIV_INT);
            act_frac  <= FRAC_W'(DEFAULT_DIV_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            pend_vld  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= xfer && bad;
            if (xfer && !bad && sync_clr) begin
                act_int  <= cfg_div_int;
                act_frac <= cfg_div_frac;
            end else if (xfer && !bad) begin
                pend_int  <= cfg_div_int;
                pend_frac <= cfg_div_frac;
                pend_vld  <= 1'b1;
            end else if (apply) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
                pend_vld <= 1'b0;
            end
        end
    end

    assign core_clr[CORE_TX] = sync_clr;
    assign core_clr[CORE_RX] = sync_clr || rx_realign;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        baud_div_core #(
            .DIV_W      (DIV_W),
            .FRAC_W     (FRAC_W),
            .OVERSAMPLE (OVERSAMPLE)
        ) u_core (
            .clk      (clk),
            .areset_n (areset_n),
            .en       (en),
            .clr      (core_clr[g]),
            .div_int  (act_int),
            .div_frac (act_frac),
            .tick_os  (tick_os[g]),
            .tick_bit (tick_bit[g]),
            .tick_mid (tick_mid[g])
        );
    end

    assign tick_tx      = tick_bit[CORE_TX];
    assign tick_os_rx   = tick_os[CORE_RX];
    assign tick_rx_mid  = tick_mid[CORE_RX];
    assign unused_ticks = tick_os[CORE_TX] ^ tick_bit[CORE_RX] ^ tick_mid[CORE_TX];
endmodule

// File: tb/tb_baud_gen_frac.sv
// Randomized bench for baud_gen_frac against a closed-form tick-time model.
module tb_baud_gen_frac;
    import baud_gen_pkg::*;

    localparam int DIV_W = 16, FRAC_W = 4, OS = 16, FR = 16;

    logic              clk = 1'b0, areset_n = 1'b0, en = 1'b0, sync_clr = 1'b0;
    logic              cfg_valid = 1'b0, rx_realign = 1'b0;
    logic [DIV_W-1:0]  cfg_div_int = '0;
    logic [FRAC_W-1:0] cfg_div_frac = '0;
    logic              cfg_ready, cfg_err, tick_tx, tick_os_rx, tick_rx_mid;

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_tx = -1, prev_tx = -1;

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .clk(clk), .areset_n(areset_n), .en(en), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div_int(cfg_div_int),
        .cfg_div_frac(cfg_div_frac), .cfg_err(cfg_err), .rx_realign(rx_realign),
        .tick_tx(tick_tx), .tick_os_rx(tick_os_rx), .tick_rx_mid(tick_rx_mid)
    );

    // Model: each core is anchored at a point in time (accumulator a0, cycles
    // already spent in the in-flight period off); tick k after the anchor falls
    // at enabled cycle (k+1)*I + floor((a0+(k+1)*F)/2^FRAC_W) - 1.
    int  m_int, m_frac, p_int, p_frac;
    bit  p_vld, m_err;
    int  e[2], a0[2], off[2], k[2], os[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int tgt(int c, int kk);
        int t;
        if (off[c] > 0) begin
            t = m_int + (a0[c] + m_frac) / FR - 1 - off[c];
            return (t < 0) ? 0 : t;
        end
        return (kk + 1) * m_int + (a0[c] + (kk + 1) * m_frac) / FR - 1;
    endfunction

    function automatic int acc_now(int c);
        return (off[c] > 0) ? a0[c] : (a0[c] + k[c] * m_frac) % FR;
    endfunction

    function automatic int elapsed(int c);
        if (off[c] > 0) return off[c] + e[c];
        return e[c] - ((k[c] == 0) ? 0 : tgt(c, k[c] - 1) + 1);
    endfunction

    function automatic void model_reset();
        m_int = DEF_DIV_INT; m_frac = DEF_DIV_FRAC;
        p_vld = 0; p_int = 0; p_frac = 0; m_err = 0;
        for (int c = 0; c < 2; c++) begin
            e[c] = 0; a0[c] = 0; off[c] = 0; k[c] = 0; os[c] = 0;
        end
    endfunction

    function automatic void model_edge(logic [1:0] tk, logic ttx);
        bit xfer, bad, apply, chg, clr;
        int ni, nf;
        int an[2], el[2];
        xfer  = cfg_valid && !p_vld;
        bad   = int'(cfg_div_int) < MIN_DIV_INT;
        apply = p_vld && (ttx || !en || sync_clr);
        chg = 0; ni = m_int; nf = m_frac;
        for (int c = 0; c < 2; c++) begin
            clr = sync_clr || (c == 1 && rx_realign);
            if (clr) begin
                e[c] = 0; a0[c] = 0; off[c] = 0; k[c] = 0; os[c] = 0;
            end else if (tk[c]) begin
                os[c] = (os[c] + 1) % OS;
                if (off[c] > 0) begin
                    a0[c] = (a0[c] + m_frac) % FR; off[c] = 0; k[c] = 0; e[c] = 0;
                end else begin
                    k[c]++; e[c]++;
                end
            end else if (en) begin
                e[c]++;
            end
        end
        if (xfer && !bad && sync_clr) begin
            chg = 1; ni = int'(cfg_div_int); nf = int'(cfg_div_frac);
        end else if (apply) begin
            chg = 1; ni = p_int; nf = p_frac; p_vld = 0;
        end
        if (xfer && !bad && !sync_clr) begin
            p_vld = 1; p_int = int'(cfg_div_int); p_frac = int'(cfg_div_frac);
        end
        if (chg) begin
            for (int c = 0; c < 2; c++) begin
                an[c] = acc_now(c); el[c] = elapsed(c);
            end
            m_int = ni; m_frac = nf;
            for (int c = 0; c < 2; c++) begin
                a0[c] = an[c]; off[c] = el[c]; k[c] = 0; e[c] = 0;
            end
        end
        m_err = xfer && bad;
    endfunction

    task automatic step();
        logic [1:0] tk;
        logic [4:0] exp;
        @(negedge clk);
        if (!areset_n) model_reset();
        for (int c = 0; c < 2; c++) tk[c] = en && (e[c] == tgt(c, k[c]));
        exp = {tk[0] && os[0] == OS - 1, tk[1], tk[1] && os[1] == OS/2 - 1, !p_vld, m_err};
        chk("outs", 32'({tick_tx, tick_os_rx, tick_rx_mid, cfg_ready, cfg_err}), 32'(exp));
        if (tick_tx) begin prev_tx = last_tx; last_tx = cyc; end
        @(posedge clk);
        if (areset_n) model_edge(tk, exp[4]);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input int di, input int df);
        bit done;
        done = 0;
        cfg_valid = 1'b1; cfg_div_int = DIV_W'(di); cfg_div_frac = FRAC_W'(df);
        for (int i = 0; i < 20000 && !done; i++) begin
            done = !p_vld;
            step();
        end
        cfg_valid = 1'b0;
        if (!done) chk("cfg_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc;
        model_reset();
        run(3);
        areset_n = 1'b1;
        en = 1'b1;
        run(10500);
        chk("tx_period_default", 32'(last_tx - prev_tx), 32'd5208);

        en = 1'b0;
        offer(4, 0);
        run(2);
        en = 1'b1;
        run(200);
        prev_tx = -1; last_tx = -1;
        run(140);
        chk("tx_period_int4", 32'(last_tx - prev_tx), 32'd64);

        offer(4, 4);
        run(300);
        rx_realign = 1'b1; run(1); rx_realign = 1'b0;
        run(100);
        offer(1, 0);
        run(20);
        offer(8, 0);
        run(400);

        for (int i = 0; i < 4000; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            rx_realign = ($urandom_range(0, 49) == 0);
            sync_clr   = ($urandom_range(0, 199) == 0);
            if (!cfg_valid && $urandom_range(0, 29) == 0) begin
                cfg_valid    = 1'b1;
                cfg_div_int  = DIV_W'($urandom_range(0, 12));
                cfg_div_frac = FRAC_W'($urandom_range(0, 15));
            end
            acc = cfg_valid && !p_vld;
            step();
            if (acc) cfg_valid = 1'b0;
        end
        en = 1'b1; rx_realign = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
        run(50);

        offer(6, 3);
        run(3);
        chk("pending_before_reset", 32'(cfg_ready), 32'd0);
        areset_n = 1'b0;
        run(2);
        areset_n = 1'b1;
        run(800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
